nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Controls one fully-connected layer of the FastNeurons NN pipeline.
- Steps the shared MAC datapath through every (neuron, input) pair: clears the accumulator, issues one MAC enable per input, triggers the activation, then writes the result into the layer output buffer.
- Uses a 4-phase start/ack handshake with the previous and next layer.
- Replaces the free-running per-layer ack counter with a full scheduler.

Parameters:
- N_IN, 2, inputs per neuron (fan-in); ≥1.
- N_OUT, 2, neurons in the layer; ≥1.
- IA_W, 2, input address width; 2**IA_W ≥ N_IN.
- WA_W, 3, weight address width; 2**WA_W ≥ N_IN*N_OUT.
- OA_W, 2, output address width; 2**OA_W ≥ N_OUT.

Ports:
- clk  in  1  clock; all state updates on the falling edge, as in the layer datapath.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  layer request from the previous layer; level signal, 4-phase.
- out_ready  in  1  output buffer can accept a write.
- in_addr  out  IA_W  input vector read address (k).
- w_addr  out  WA_W  weight read address (j*N_IN + k).
- mac_clr  out  1  clear the accumulator.
- mac_en  out  1  accumulate the current input×weight product.
- act_en  out  1  latch the activation of the accumulator.
- out_wr  out  1  write the activation result.
- out_addr  out  OA_W  neuron index j.
- busy  out  1  high in every state except IDLE and DONE.
- ack  out  1  layer complete.

Behaviour:
- All outputs are registered (Moore), decoded from the state and counters.
- Reset (rst=0, any time, including mid-layer):
  - state goes to IDLE immediately.
  - Counters j and k clear to 0.
  - All outputs go to 0.
- States and transitions:
  - IDLE: start=1 → CLR; otherwise stay.
  - CLR: mac_clr=1; k←0 → ACC.
  - ACC: mac_en=1; in_addr=k; w_addr=j*N_IN+k.
    - k<N_IN-1: k++, stay in ACC.
    - k=N_IN-1: → DRAIN.
  - DRAIN: no strobes; covers the 1-cycle MAC pipeline → ACT.
  - ACT: act_en=1 → WR.
  - WR: out_wr=out_ready; out_addr=j.
    - out_ready=0: hold in WR.
    - out_ready=1 and j<N_OUT-1: j++ → CLR.
    - out_ready=1 and j=N_OUT-1: → DONE.
  - DONE: ack=1; hold while start=1. When start=0: ack←0, j←0 → IDLE.
- w_addr is a running counter: +1 per ACC cycle, 0 on leaving DONE. No multiplier.
- Only one strobe (mac_clr, mac_en, act_en, out_wr) may be high in any cycle.
- Timing per neuron: N_IN+4 cycles with out_ready held high. Each out_ready=0 cycle in WR adds one cycle.
- Latency: ack rises N_OUT*(N_IN+4)+1 falling edges after the edge that samples start=1.
- start is ignored outside IDLE and DONE. Dropping start mid-layer does not abort.
- start=1 in IDLE on the edge right after DONE→IDLE begins a new pass; no dead cycle.
- Counters never wrap past N_IN-1 or N_OUT-1.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum (IDLE, CLR, ACC, DRAIN, ACT, WR, DONE);
  - a clog2-style width function;
  - the localparam MAC_LAT=1 that sets the DRAIN length.
- One sub-module, nn_mod_counter: a parameterised modulo counter with clr, inc and a terminal-count flag. It is instantiated twice, for k and for j.

Test Plan:
- Reset: rst=0 mid-ACC. All outputs are 0 immediately, without waiting for a clock edge. After release the block sits in IDLE with busy=0.
- Default params, out_ready=1, start held:
  - mac_en pulses with (in_addr,w_addr) = (0,0),(1,1), then (0,2),(1,3).
  - out_wr at out_addr 0, then 1.
  - ack rises 13 edges after start is sampled.
- Backpressure: out_ready=0 for 3 cycles at the first WR. out_wr is held low for those cycles and the state stays in WR. ack arrives at edge 16.
- Handshake:
  - ack stays 1 while start=1.
  - start→0 causes ack→0 and w_addr→0 on the next edge.
  - start=1 on the following edge begins a new pass with w_addr=0.
- N_IN=3, N_OUT=1: exactly 3 mac_en pulses and 1 out_wr; ack rises at edge 8.
- Strobe exclusivity: assertion that at most one of mac_clr/mac_en/act_en/out_wr is high, checked over a run with random out_ready.

Source files
------------

// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and helpers for the NN layer sequencer.
// Holds the state encoding and datapath latency constants.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    DRAIN,
    ACT,
    WR,
    DONE
  } nn_state_e;

  // Cycles between the last MAC enable and a valid accumulator.
  localparam int MAC_LAT = 1;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int nn_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control bundle between the layer sequencer and its datapath
// and neighbouring layers.
interface nn_layer_sequencer_if #(
  parameter int IA_W = 2,
  parameter int WA_W = 3,
  parameter int OA_W = 2
);

  logic            start;
  logic            out_ready;
  logic [IA_W-1:0] in_addr;
  logic [WA_W-1:0] w_addr;
  logic            mac_clr;
  logic            mac_en;
  logic            act_en;
  logic            out_wr;
  logic [OA_W-1:0] out_addr;
  logic            busy;
  logic            ack;

  modport master (
    input  start,
    input  out_ready,
    output in_addr,
    output w_addr,
    output mac_clr,
    output mac_en,
    output act_en,
    output out_wr,
    output out_addr,
    output busy,
    output ack
  );

  modport slave (
    output start,
    output out_ready,
    input  in_addr,
    input  w_addr,
    input  mac_clr,
    input  mac_en,
    input  act_en,
    input  out_wr,
    input  out_addr,
    input  busy,
    input  ack
  );

endinterface

// File: rtl/nn_layer_sequencer_counter.sv
// Saturating modulo counter used for the input and neuron indices.
// tc_o flags the last value; inc never moves past it.
module nn_mod_counter
  import nn_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = nn_clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MOD - 1));
  assign cnt_o = cnt_q;

  // Clear wins over increment; hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, updated with the datapath on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: walks the shared MAC over every (neuron, input)
// pair and handshakes start/ack with the neighbouring layers.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IA_W  = 2,
  parameter int WA_W  = 3,
  parameter int OA_W  = 2
) (
  input logic                  clk,
  input logic                  rst,
  nn_layer_sequencer_if.master bus
);

  localparam int KW = nn_clog2(N_IN);
  localparam int JW = nn_clog2(N_OUT);
  localparam int DW = nn_clog2(MAC_LAT);

  nn_state_e state_q, state_d;

  logic [KW-1:0] k_cnt;
  logic          k_tc, k_clr, k_inc;
  logic [JW-1:0] j_cnt;
  logic          j_tc, j_clr, j_inc;

  logic [DW-1:0]   drn_q, drn_d;
  logic [WA_W-1:0] wcnt_q, wcnt_d;

  logic            mac_clr_q, mac_clr_d;
  logic            mac_en_q, mac_en_d;
  logic            act_en_q, act_en_d;
  logic            out_wr_q, out_wr_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [IA_W-1:0] in_addr_q, in_addr_d;
  logic [WA_W-1:0] w_addr_q, w_addr_d;
  logic [OA_W-1:0] out_addr_q, out_addr_d;

  nn_mod_counter #(.MOD(N_IN)) u_k (
    .clk   (clk),
    .rst   (rst),
    .clr_i (k_clr),
    .inc_i (k_inc),
    .cnt_o (k_cnt),
    .tc_o  (k_tc)
  );

  nn_mod_counter #(.MOD(N_OUT)) u_j (
    .clk   (clk),
    .rst   (rst),
    .clr_i (j_clr),
    .inc_i (j_inc),
    .cnt_o (j_cnt),
    .tc_o  (j_tc)
  );

  // Next state, counter controls and registered output decode.
  always_comb begin
    state_d    = state_q;
    k_clr      = 1'b0;
    k_inc      = 1'b0;
    j_clr      = 1'b0;
    j_inc      = 1'b0;
    drn_d      = '0;
    wcnt_d     = wcnt_q;
    mac_clr_d  = 1'b0;
    mac_en_d   = 1'b0;
    act_en_d   = 1'b0;
    out_wr_d   = 1'b0;
    busy_d     = 1'b1;
    ack_d      = 1'b0;
    in_addr_d  = '0;
    w_addr_d   = w_addr_q;
    out_addr_d = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) state_d = CLR;
      end
      CLR: begin
        mac_clr_d = 1'b1;
        k_clr     = 1'b1;
        state_d   = ACC;
      end
      ACC: begin
        mac_en_d  = 1'b1;
        in_addr_d = IA_W'(k_cnt);
        w_addr_d  = wcnt_q;
        wcnt_d    = wcnt_q + WA_W'(1);
        if (k_tc) state_d = DRAIN;
        else      k_inc   = 1'b1;
      end
      DRAIN: begin
        if (drn_q == DW'(MAC_LAT - 1)) state_d = ACT;
        else                           drn_d   = drn_q + DW'(1);
      end
      ACT: begin
        act_en_d = 1'b1;
        state_d  = WR;
      end
      WR: begin
        out_wr_d   = bus.out_ready;
        out_addr_d = OA_W'(j_cnt);
        if (bus.out_ready) begin
          if (j_tc) begin
            state_d = DONE;
          end else begin
            j_inc   = 1'b1;
            state_d = CLR;
          end
        end
      end
      DONE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          ack_d = 1'b1;
        end else begin
          j_clr    = 1'b1;
          wcnt_d   = '0;
          w_addr_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, drain/weight counters and output registers.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      drn_q      <= '0;
      wcnt_q     <= '0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      act_en_q   <= 1'b0;
      out_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      drn_q      <= drn_d;
      wcnt_q     <= wcnt_d;
      mac_clr_q  <= mac_clr_d;
      mac_en_q   <= mac_en_d;
      act_en_q   <= act_en_d;
      out_wr_q   <= out_wr_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign bus.mac_clr  = mac_clr_q;
  assign bus.mac_en   = mac_en_q;
  assign bus.act_en   = act_en_q;
  assign bus.out_wr   = out_wr_q;
  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.out_addr = out_addr_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for the layer sequencer: two instances (2x2 and 3x1)
// against a position-based schedule model plus literal anchors.
module tb_nn_layer_sequencer;

  typedef struct packed {
    logic       mac_clr;
    logic       mac_en;
    logic       act_en;
    logic       out_wr;
    logic       busy;
    logic       ack;
    logic [7:0] in_addr;
    logic [7:0] w_addr;
    logic [7:0] out_addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int chk = 0;
  int err = 0;
  int ecnt = 0;

  int   md[2];
  int   pp[2];
  int   wl[2];
  int   tst[2];
  int   ar[2];
  logic pa[2];
  obs_t ex[2];

  logic [7:0] qa_in[$];
  logic [7:0] qa_w[$];
  logic [7:0] qa_wr[$];
  int nb_mac = 0;
  int nb_wr = 0;

  nn_layer_sequencer_if #(.IA_W(2), .WA_W(3), .OA_W(2)) ifa ();
  nn_layer_sequencer_if #(.IA_W(2), .WA_W(2), .OA_W(1)) ifb ();

  nn_layer_sequencer #(
    .N_IN(2), .N_OUT(2), .IA_W(2), .WA_W(3), .OA_W(2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  nn_layer_sequencer #(
    .N_IN(3), .N_OUT(1), .IA_W(2), .WA_W(2), .OA_W(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a layer is a list of positions 1..N_OUT*(N_IN+4); each
  // neuron is clr, N_IN macs, drain, act, write. Outputs appear one
  // edge after the position is reached. Writes stall while !ready.
  task automatic model_step(input int i, input int ni, input int no,
                            input logic st, input logic rdy);
    obs_t e;
    int L, tot, j, ph;
    L   = ni + 4;
    tot = no * L;
    e = '0;
    e.w_addr = 8'(wl[i]);
    if (md[i] == 1) begin
      j  = (pp[i] - 1) / L;
      ph = (pp[i] - 1) % L;
      e.busy = 1'b1;
      if (ph == 0) begin
        e.mac_clr = 1'b1;
      end else if (ph <= ni) begin
        e.mac_en  = 1'b1;
        e.in_addr = 8'(ph - 1);
        e.w_addr  = 8'(j * ni + ph - 1);
      end else if (ph == ni + 2) begin
        e.act_en = 1'b1;
      end else if (ph == ni + 3) begin
        e.out_wr   = rdy;
        e.out_addr = 8'(j);
      end
      if (!(ph == ni + 3 && !rdy)) begin
        if (pp[i] == tot) md[i] = 2;
        else pp[i]++;
      end
    end else if (md[i] == 2) begin
      e.ack = st;
      if (!st) begin
        e.w_addr = '0;
        md[i] = 0;
      end
    end else if (st) begin
      md[i]  = 1;
      pp[i]  = 1;
      tst[i] = ecnt;
    end
    wl[i] = int'(e.w_addr);
    ex[i] = e;
  endtask

  // Model advances on the same edge the DUT updates on.
  always @(negedge clk) begin
    ecnt++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        md[i] = 0;
        pp[i] = 0;
        wl[i] = 0;
        ex[i] = '0;
      end
    end else begin
      model_step(0, 2, 2, ifa.start, ifa.out_ready);
      model_step(1, 3, 1, ifb.start, ifb.out_ready);
    end
  end

  // Compare on the opposite edge, record strobes, check exclusivity.
  always @(posedge clk) begin
    obs_t oa, ob;
    if (rst) begin
      oa = '{ifa.mac_clr, ifa.mac_en, ifa.act_en, ifa.out_wr,
             ifa.busy, ifa.ack, 8'(ifa.in_addr), 8'(ifa.w_addr),
             8'(ifa.out_addr)};
      ob = '{ifb.mac_clr, ifb.mac_en, ifb.act_en, ifb.out_wr,
             ifb.busy, ifb.ack, 8'(ifb.in_addr), 8'(ifb.w_addr),
             8'(ifb.out_addr)};
      chk++;
      if (oa !== ex[0]) begin
        err++;
        $display("FAIL cyc_a edge %0d: got %h expected %h",
                 ecnt, oa, ex[0]);
      end
      chk++;
      if (ob !== ex[1]) begin
        err++;
        $display("FAIL cyc_b edge %0d: got %h expected %h",
                 ecnt, ob, ex[1]);
      end
      chk++;
      assert ($onehot0({oa.mac_clr, oa.mac_en, oa.act_en, oa.out_wr}) &&
              $onehot0({ob.mac_clr, ob.mac_en, ob.act_en, ob.out_wr}))
      else begin
        err++;
        $display("FAIL strobe_excl: got a=%b b=%b expected onehot0",
                 {oa.mac_clr, oa.mac_en, oa.act_en, oa.out_wr},
                 {ob.mac_clr, ob.mac_en, ob.act_en, ob.out_wr});
      end
      if (oa.mac_en) begin
        qa_in.push_back(oa.in_addr);
        qa_w.push_back(oa.w_addr);
      end
      if (oa.out_wr) qa_wr.push_back(oa.out_addr);
      if (ob.mac_en) nb_mac++;
      if (ob.out_wr) nb_wr++;
      if (oa.ack && !pa[0]) ar[0] = ecnt - tst[0];
      if (ob.ack && !pa[1]) ar[1] = ecnt - tst[1];
      pa[0] = oa.ack;
      pa[1] = ob.ack;
    end else begin
      pa[0] = 1'b0;
      pa[1] = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int i, input int maxc);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (((i == 0) ? ifa.ack : ifb.ack) !== 1'b1 && n < maxc);
    check("ack_wait", int'((i == 0) ? ifa.ack : ifb.ack), 1);
  endtask

  task automatic clear_rec();
    qa_in.delete();
    qa_w.delete();
    qa_wr.delete();
    nb_mac = 0;
    nb_wr  = 0;
  endtask

  initial begin
    int ein[4];
    int ew[4];
    int n;
    ein = '{0, 1, 0, 1};
    ew  = '{0, 1, 2, 3};
    ar  = '{0, 0};
    ifa.start = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.start = 1'b0;
    ifb.out_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    check("idle_busy", int'(ifa.busy), 0);
    check("idle_ack", int'(ifa.ack), 0);

    clear_rec();
    ifa.start = 1'b1;
    ifb.start = 1'b1;
    wait_ack(0, 40);
    check("p1_ack_edge_a", ar[0], 13);
    check("p1_mac_n", qa_in.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa_in.size()) begin
        check("p1_in_addr", int'(qa_in[i]), ein[i]);
        check("p1_w_addr", int'(qa_w[i]), ew[i]);
      end
    end
    check("p1_wr_n", qa_wr.size(), 2);
    if (qa_wr.size() == 2) begin
      check("p1_wr0", int'(qa_wr[0]), 0);
      check("p1_wr1", int'(qa_wr[1]), 1);
    end
    check("b_ack_edge", ar[1], 8);
    check("b_mac_n", nb_mac, 3);
    check("b_wr_n", nb_wr, 1);
    tick(3);
    check("ack_hold", int'(ifa.ack), 1);

    ifa.start = 1'b0;
    ifb.start = 1'b0;
    tick(1);
    check("drop_ack", int'(ifa.ack), 0);
    check("drop_waddr", int'(ifa.w_addr), 0);
    clear_rec();
    ifa.start = 1'b1;
    ifa.out_ready = 1'b0;
    tick(9);
    ifa.out_ready = 1'b1;
    wait_ack(0, 60);
    check("bp_ack_edge", ar[0], 16);
    check("bp_first_w", (qa_w.size() > 0) ? int'(qa_w[0]) : -1, 0);
    check("bp_wr_n", qa_wr.size(), 2);
    ifa.start = 1'b0;
    tick(2);

    for (int p = 0; p < 3; p++) begin
      ifa.start = 1'b1;
      ifb.start = 1'b1;
      n = 0;
      while (!(ifa.ack && ifb.ack) && n < 200) begin
        ifa.out_ready = 1'($urandom_range(0, 1));
        ifb.out_ready = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      check("rnd_done", int'(ifa.ack & ifb.ack), 1);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      ifa.out_ready = 1'b1;
      ifb.out_ready = 1'b1;
      tick(2);
    end

    clear_rec();
    ifa.start = 1'b1;
    tick(2);
    ifa.start = 1'b0;
    tick(20);
    check("noabort_wr_n", qa_wr.size(), 2);
    check("noabort_busy", int'(ifa.busy), 0);
    check("noabort_ack", int'(ifa.ack), 0);

    ifa.start = 1'b1;
    ifb.start = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(ifa.mac_en && ifa.w_addr == 3'd2) && n < 20);
    check("rst_reach_acc", int'(ifa.mac_en), 1);
    rst = 1'b0;
    #1;
    check("rst_mac_clr", int'(ifa.mac_clr), 0);
    check("rst_mac_en", int'(ifa.mac_en), 0);
    check("rst_act_en", int'(ifa.act_en), 0);
    check("rst_out_wr", int'(ifa.out_wr), 0);
    check("rst_busy", int'(ifa.busy), 0);
    check("rst_ack", int'(ifa.ack), 0);
    check("rst_in_addr", int'(ifa.in_addr), 0);
    check("rst_w_addr", int'(ifa.w_addr), 0);
    check("rst_out_addr", int'(ifa.out_addr), 0);
    check("rst_busy_b", int'(ifb.busy), 0);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("post_rst_busy", int'(ifa.busy), 0);
    check("post_rst_ack", int'(ifa.ack), 0);
    ifa.start = 1'b1;
    wait_ack(0, 40);
    check("post_rst_ack_edge", ar[0], 13);
    ifa.start = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
